// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver FSM state encoding.
// PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } rx_state_e;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module rx_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start/8 data/optional parity/stop, single-entry holding register.
// Define UART_RX_PARITY_EN to build in the PARITY state and even-parity checking.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic                 parity_en_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] HalfBit = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] FullBit = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  rx_state_e             state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  rx_sync, rx_prev_q, rx_fall;
  logic                  load;
  logic [DATA_BITS-1:0]  data_q;
  logic                  valid_q, ferr_q, ovr_q;

  rx_synchronizer u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_sync)
  );

  // A line that is already low after reset never produces a fall.
  assign rx_fall = rx_prev_q & ~rx_sync;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_err_q, par_err_d;
  logic perr_q;
`else
  logic unused_parity_en;
  assign unused_parity_en = parity_en_i;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d  = par_en_q;
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (rx_fall) begin
          state_d = StStart;
`ifdef UART_RX_PARITY_EN
          par_en_d = parity_en_i;
`endif
        end
      end
      StStart: begin
        if (timer_q == HalfBit) begin
          timer_d = '0;
          if (rx_sync) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end
      end
      StData: begin
        if (timer_q == FullBit) begin
          timer_d = '0;
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (timer_q == FullBit) begin
          timer_d   = '0;
          par_err_d = rx_sync ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (timer_q == FullBit) begin
          timer_d = '0;
          load    = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_prev_q <= rx_sync;
    end
  end

  // Holding register: a load always wins, so an unconsumed byte is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= load | (valid_q & ~ready_i);
      ovr_q   <= load & valid_q & ~ready_i;
      if (load) begin
        data_q <= shift_q;
        ferr_q <= ~rx_sync;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_err_q <= par_err_d;
      if (load) begin
        perr_q <= par_err_q;
      end
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1042, meaning clk cycles per UART bit (10 MHz / 9600 baud); legal values are at least 4.
REQ-002 SHALL have these ports:
- clk  in  1  system clock, 10 MHz.
- rst  in  1  reset, asynchronous, active-high.
- rx_i  in  1  serial line, idle high, asynchronous to clk.
- parity_en_i  in  1  enables the parity bit; sampled at start-bit detection.
- data_o  out  8  received byte.
- valid_o  out  1  data_o holds an unconsumed byte.
- ready_i  in  1  consumer accepts the byte.
- parity_err_o  out  1  parity error for the byte on data_o.
- frame_err_o  out  1  stop bit was read as 0 for the byte on data_o.
- overrun_o  out  1  one-cycle pulse when an unconsumed byte is overwritten.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 SHALL pass rx_i through a 2-flop synchronizer (2-cycle latency); all further logic SHALL use the synchronized signal only.
REQ-004 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, and SHALL use an internal bit-timer and a 3-bit bit counter.
REQ-005 IDLE: a 1->0 edge on the synchronized line SHALL clear the timer, latch parity_en_i, and enter START. A line held low SHALL NOT trigger a start.
REQ-006 START: at timer = CLKS_PER_BIT/2-1, the FSM SHALL sample the line. If it reads 1 (glitch), go to IDLE with no outputs changed. If it reads 0, clear the timer and enter DATA.
REQ-007 DATA: each time the timer reaches CLKS_PER_BIT-1, the FSM SHALL sample one bit, shifting it in at the MSB so bytes are received LSB first. The timer then wraps to 0. After the 8th bit, go to PARITY if parity was latched, otherwise go to STOP.
REQ-008 PARITY: the FSM SHALL sample one bit using the REQ-007 timing. The parity error SHALL be set when the sampled bit XOR the XOR-reduction of the byte = 1 (even parity).
REQ-009 STOP: the FSM SHALL sample at CLKS_PER_BIT-1. A 0 SHALL set the frame error. The FSM SHALL then load the holding register and return to IDLE in the same cycle.
REQ-010 Loading the holding register SHALL update data_o, parity_err_o and frame_err_o, and SHALL set valid_o on the next clk edge. A byte with an error SHALL still be delivered.
REQ-011 valid_o SHALL stay high until a cycle where valid_o & ready_i; valid_o SHALL then clear on the next edge. ready_i while valid_o=0 SHALL be ignored.
REQ-012 A load while valid_o=1 and ready_i=0 SHALL overwrite the holding register, keep valid_o=1, and pulse overrun_o for one cycle.
REQ-013 A load in the same cycle as valid_o & ready_i SHALL load the new byte with valid_o remaining 1, and SHALL NOT pulse overrun_o.
REQ-014 Sample-to-valid_o latency SHALL be 1 cycle. Line-edge-to-IDLE-exit latency SHALL be 3 cycles (synchronizer + edge detect).

Reset
REQ-015 On rst: state SHALL be IDLE; the timer and bit counter SHALL be 0; the synchronizer and edge-detect flops SHALL be 1; data_o SHALL be 8'h00; valid_o, parity_err_o, frame_err_o, overrun_o and busy_o SHALL be 0.
REQ-016 rst asserted mid-frame SHALL abort the frame with no partial byte delivered. After release, the receiver SHALL wait for a fresh 1->0 edge.

Configuration
REQ-017 Macro UART_RX_PARITY_EN: when defined, PARITY state and checking SHALL be present as specified. When undefined, the PARITY state SHALL be absent, parity_en_i SHALL be ignored, frames SHALL always be start + 8 data + stop, and parity_err_o SHALL be tied 0.

Structure
REQ-018 Package uart_pkg SHALL hold the rx state enum typedef and DATA_BITS = 8. The transmitter and receiver SHALL share DATA_BITS.
REQ-019 Sub-module rx_synchronizer SHALL implement the 2-flop synchronizer with a reset value of 1. All other logic SHALL be in uart_receiver.

Verification
REQ-020 With CLKS_PER_BIT=16, the bench SHALL cover these directed scenarios:
- 8'hA5, no parity, ready_i=1 -> one valid_o cycle, data_o=8'hA5, both error flags 0.
- 8'h3C, parity_en_i=1, parity bit 0 -> parity_err_o=0.
- 8'h3C, parity_en_i=1, parity bit 1 -> parity_err_o=1, data_o=8'h3C.
- Stop bit forced 0 on 8'h55 -> frame_err_o=1. A line held low afterward -> no new frame.
- 6-cycle low glitch on rx_i -> FSM returns to IDLE, valid_o stays 0.
- Two frames 8'h11 then 8'h22, ready_i=0 -> overrun_o pulses once, data_o=8'h22, valid_o=1.
- Repeat the 8'h11/8'h22 sequence with ready_i=1 in the load cycle -> no overrun_o.
- rst asserted mid-DATA -> all outputs 0; next clean frame 8'hF0 received correctly.
